bcd_to_bin_converter: RTL and testbench
=======================================

# bcd_to_bin_converter

Sequential BCD-to-binary converter, the reverse of the stopwatch's binary-to-BCD path. It accepts a packed multi-digit BCD number, such as a preset time entered on switches or a keypad, and produces the equivalent unsigned binary value. The result can preload the millisecond counter or feed a comparator. Conversion uses Horner accumulation, one digit per clock, behind a start/busy/done handshake.

## Interface
Parameters:
- DIGITS, 6, number of BCD digits converted.
- WIDTH, 20, binary result width. Must satisfy 2^WIDTH > 10^DIGITS − 1.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled on each rising Clock edge.
- bcd_in  input  4*DIGITS  packed BCD; nibble k (bits 4k+3:4k) is digit k, digit 0 is least significant.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bin_value and error are updated.
- bin_value  output  WIDTH  last converted value; held until the next done.
- error  output  1  set with done if any captured nibble was > 9; held until the next done.

## Operation
- Reset value of every output is 0: busy, done, bin_value and error. The state is IDLE, and the accumulator, digit shift register and counter are all 0.
- States are IDLE and CONV.
- **IDLE, start = 1:**
  - Capture bcd_in into the digit shift register.
  - Set the internal error flag to the OR over all nibbles of (nibble > 9).
  - Clear the accumulator to 0 and the counter to 0.
  - Go to CONV and set busy to 1.
- **CONV, each edge:**
  - acc ← acc*10 + top digit (digit DIGITS−1 first).
  - Shift the digit register left by one nibble and increment the counter.
  - Arithmetic is acc*10 = (acc<<3) + (acc<<1), computed in WIDTH bits; the top digit is zero-extended.
- **CONV, counter = DIGITS−1:** the edge performs the final accumulate and also:
  - bin_value ← 0 if the error flag is set, otherwise the new acc.
  - error ← error flag; done ← 1; busy ← 0; next state IDLE.
- done is 0 on every edge other than the completion edge.
- start is ignored while in CONV; there is no queueing.
- Invalid nibbles (A–F) do not shorten the conversion. Latency is constant, and the result is forced to 0 with error = 1.
- Reset asserted mid-conversion aborts immediately. All outputs return to 0, and no done pulse is generated.

## Timing
- Call the edge that accepts start E0. busy is 1 after E0.
- The accumulation edges are E1..E_DIGITS. done, bin_value and error are valid after E_DIGITS, and busy is 0 in that same cycle.
- Start-to-done latency is DIGITS edges (6 by default).
- A start asserted during the done cycle is accepted at the next edge. Back-to-back throughput is one conversion per DIGITS+1 cycles.
- bcd_in need only be stable at E0.

## Structure
- A shared package holds:
  - the state encoding (IDLE, CONV);
  - the BCD digit width constant (4);
  - the invalid-digit threshold constant (9).
- One combinational sub-module, mul10_add, computes acc*10 + digit in WIDTH bits. It is reusable by future decimal-entry blocks.
- The top module holds the FSM, digit shift register, counter, accumulator and output registers.

## Test plan
- Reset, then idle with no start: all outputs are 0 and remain 0 for 20 cycles.
- bcd_in = 0x999999, start for 1 cycle: busy high for 6 cycles. done pulses after the 6th edge with bin_value = 0xF423F and error = 0.
- bcd_in = 0x012345, then bcd_in = 0x000000 started in the done cycle: bin_value = 0x03039, then bin_value = 0x00000 7 cycles later, with error = 0 for both.
- bcd_in = 0x12A456: done after 6 edges with bin_value = 0 and error = 1. A following conversion of 0x000007 gives bin_value = 7 and error = 0.
- Start with 0x000100, then start held high with bcd_in changed to 0x999999 during busy: the result is 0x00064. The second request is accepted only after done.
- Start with 0x555555 and assert Reset_n low at E3: outputs are immediately 0 and no done pulse occurs. After release, a fresh conversion of 0x000042 gives 0x0002A.

Source files
------------

// File: rtl/bcd_to_bin_converter_pkg.sv
// Shared constants and state encoding for the sequential BCD-to-binary converter
// and its helper blocks.
package bcd_to_bin_converter_pkg;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_to_bin_converter_mul10_add.sv
// Combinational Horner step: result = acc*10 + digit, truncated to WIDTH bits.
// Kept separate so other decimal-entry blocks can reuse it.
module mul10_add
  import bcd_to_bin_converter_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [BCD_W-1:0] digit_i,
  output logic [WIDTH-1:0] result_o
);

  // Shift-and-add form of acc*10 avoids a general multiplier.
  assign result_o = (acc_i << 3) + (acc_i << 1) + WIDTH'(digit_i);

endmodule

// File: rtl/bcd_to_bin_converter.sv
// Converts a packed multi-digit BCD number to unsigned binary, one digit per
// clock (most significant first), behind a start/busy/done handshake.
module bcd_to_bin_converter
  import bcd_to_bin_converter_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int WIDTH  = 20
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic                    start,
  input  logic [BCD_W*DIGITS-1:0] bcd_in,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        bin_value,
  output logic                    error
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  state_e                  state_q;
  logic [BCD_W*DIGITS-1:0] digits_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [WIDTH-1:0]        acc_q;
  logic [WIDTH-1:0]        acc_d;
  logic                    err_flag_q;
  logic                    busy_q;
  logic                    done_q;
  logic [WIDTH-1:0]        bin_value_q;
  logic                    error_q;

  logic                    any_invalid;
  logic [BCD_W-1:0]        top_digit;

  assign top_digit = digits_q[BCD_W*DIGITS-1 -: BCD_W];

  // NOTE: give every always_comb output a default before any conditional
  // assignment; otherwise synthesis infers a latch to hold the old value.
  always_comb begin : invalid_scan
    any_invalid = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_in[BCD_W*k +: BCD_W] > BCD_W'(BCD_MAX)) begin
        any_invalid = 1'b1;
      end
    end
  end

  mul10_add #(
    .WIDTH (WIDTH)
  ) u_mul10_add (
    .acc_i    (acc_q),
    .digit_i  (top_digit),
    .result_o (acc_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in this block.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      digits_q    <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      err_flag_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bin_value_q <= '0;
      error_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            digits_q   <= bcd_in;
            err_flag_q <= any_invalid;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= CONV;
          end
        end
        CONV: begin
          acc_q    <= acc_d;
          digits_q <= digits_q << BCD_W;
          cnt_q    <= cnt_q + 1'b1;
          // Invalid digits still run the full latency; only the result is forced.
          if (cnt_q == LAST_CNT) begin
            bin_value_q <= err_flag_q ? '0 : acc_d;
            error_q     <= err_flag_q;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bin_value = bin_value_q;
  assign error     = error_q;

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Directed scoreboard bench for bcd_to_bin_converter: expected results are
// queued at start and popped when done pulses.
module tb_bcd_to_bin_converter;

  localparam int DIGITS = 6;
  localparam int WIDTH  = 20;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] value;
  } exp_t;

  logic                  Clock   = 1'b0;
  logic                  Reset_n = 1'b0;
  logic                  start   = 1'b0;
  logic [4*DIGITS-1:0]   bcd_in  = '0;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      bin_value;
  logic                  error;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 Clock = ~Clock;

  bcd_to_bin_converter #(
    .DIGITS (DIGITS),
    .WIDTH  (WIDTH)
  ) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .start     (start),
    .bcd_in    (bcd_in),
    .busy      (busy),
    .done      (done),
    .bin_value (bin_value),
    .error     (error)
  );

  // Reference: weighted digit sum, invalid nibble forces 0 with error.
  function automatic exp_t model(logic [4*DIGITS-1:0] bcd);
    exp_t        e;
    int unsigned v;
    int unsigned w;
    logic [3:0]  d;
    e.err = 1'b0;
    v = 0;
    w = 1;
    for (int k = 0; k < DIGITS; k++) begin
      d = 4'(bcd >> (4*k));
      if (d > 4'd9) e.err = 1'b1;
      v = v + 32'(d) * w;
      w = w * 10;
    end
    e.value = e.err ? '0 : WIDTH'(v);
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives start for one edge from a negedge; bcd_in is scrambled afterwards.
  task automatic launch(logic [4*DIGITS-1:0] bcd);
    bcd_in = bcd;
    start  = 1'b1;
    sb.push_back(model(bcd));
    @(negedge Clock);
    start  = 1'b0;
    bcd_in = 24'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Called one negedge after the accepting edge; returns on the done cycle.
  task automatic wait_done(string tag, int exp_edges);
    int   n      = 0;
    int   busy_n = 0;
    exp_t e;
    while (!done && n < 20) begin
      if (busy) busy_n++;
      @(negedge Clock);
      n++;
    end
    if (!done) begin
      check({tag, "_timeout"}, 32'(done), 32'd1);
      return;
    end
    check({tag, "_latency"}, n, exp_edges);
    check({tag, "_busy_cycles"}, busy_n, exp_edges);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (sb.size() == 0) begin
      check({tag, "_unexpected_done"}, 32'(done), 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_value"}, 32'(bin_value), 32'(e.value));
      check({tag, "_error"}, 32'(error), 32'(e.err));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge Clock);
    check("reset_outputs", 32'({busy, done, error, bin_value}), 32'd0);
    Reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      check("idle_quiet", 32'({busy, done, error, bin_value}), 32'd0);
    end

    launch(24'h999999);
    wait_done("all_nines", DIGITS);

    launch(24'h012345);
    wait_done("d012345", DIGITS);
    launch(24'h000000);
    wait_done("b2b_zero", DIGITS);

    launch(24'h12A456);
    wait_done("invalid", DIGITS);
    launch(24'h000007);
    wait_done("after_invalid", DIGITS);
    @(negedge Clock);
    check("done_one_cycle", 32'(done), 32'd0);
    check("value_held", 32'(bin_value), 32'd7);

    // start held high; the changed bcd_in must be ignored until done.
    bcd_in = 24'h000100;
    start  = 1'b1;
    sb.push_back(model(24'h000100));
    @(negedge Clock);
    check("held_busy", 32'(busy), 32'd1);
    bcd_in = 24'h999999;
    wait_done("held_first", DIGITS);
    sb.push_back(model(24'h999999));
    @(negedge Clock);
    start = 1'b0;
    check("held_second_busy", 32'(busy), 32'd1);
    wait_done("held_second", DIGITS);

    // Reset just after E3 aborts the conversion with no done pulse.
    launch(24'h555555);
    repeat (2) @(negedge Clock);
    @(posedge Clock);
    #1 Reset_n = 1'b0;
    #1 check("abort_outputs", 32'({busy, done, error, bin_value}), 32'd0);
    sb.delete();
    repeat (2) begin
      @(negedge Clock);
      check("abort_no_done_in_reset", 32'(done), 32'd0);
    end
    Reset_n = 1'b1;
    repeat (8) begin
      @(negedge Clock);
      check("abort_quiet", 32'({busy, done}), 32'd0);
    end
    launch(24'h000042);
    wait_done("after_abort", DIGITS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
